// File: rtl/sm_seq_pkg.sv
// Shared definitions for the step sequencer: controller states and default widths.
package sm_seq_pkg;

   localparam int SEQ_COUNT_W = 8;
   localparam int SEQ_TMO_W   = 8;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ISSUE = 3'd1,
      WAIT  = 3'd2,
      DONE  = 3'd3,
      ERROR = 3'd4
   } seq_state_t;

endpackage

// File: rtl/seq_watchdog.sv
// Per-step watchdog: counts cycles spent waiting for done and flags when the
// programmed limit is about to be exhausted. A zero limit disables it.
module seq_watchdog
   import sm_seq_pkg::*;
#(
   parameter int TMO_W = SEQ_TMO_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             run,
   input  logic [TMO_W-1:0] limit,
   output logic             expired
);

   localparam logic [TMO_W-1:0] ONE = TMO_W'(1);

   logic [TMO_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (run) begin
         count <= count + ONE;
      end
   end

   // Firing at limit-1 gives exactly 'limit' waiting cycles before the error edge.
   assign expired = run && (limit != '0) && (count == limit - ONE);

endmodule

// File: rtl/step_sequencer.sv
// Start/done step controller: pulses start, waits for done, counts steps up to a
// limit (or free-runs), with a watchdog and sticky finished/timeout status.
module step_sequencer
   import sm_seq_pkg::*;
#(
   parameter int COUNT_W = SEQ_COUNT_W,
   parameter int TMO_W   = SEQ_TMO_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               enable,
   input  logic [COUNT_W-1:0] step_limit,
   input  logic [TMO_W-1:0]   tmo_cycles,
   input  logic               done,
   output logic               start,
   output logic               busy,
   output logic [COUNT_W-1:0] count,
   output logic               finished,
   output logic               timeout_err
);

   localparam logic [COUNT_W-1:0] ONE = COUNT_W'(1);

   seq_state_t         state;
   seq_state_t         next_state;
   logic               wd_clear;
   logic               wd_run;
   logic               wd_expired;
   logic [COUNT_W-1:0] count_inc;

   assign wd_clear  = (state == ISSUE);
   assign wd_run    = (state == WAIT) && !done;
   assign count_inc = count + ONE;

   seq_watchdog #(
      .TMO_W (TMO_W)
   ) u_watchdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (wd_clear),
      .run     (wd_run),
      .limit   (tmo_cycles),
      .expired (wd_expired)
   );

   // A done in WAIT always takes priority over a coincident watchdog expiry.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (enable) next_state = ISSUE;
         end
         ISSUE: begin
            next_state = WAIT;
         end
         WAIT: begin
            if (done) begin
               if ((step_limit != '0) && (count_inc == step_limit)) next_state = DONE;
               else if (!enable)                                    next_state = IDLE;
               else                                                 next_state = ISSUE;
            end else if (wd_expired) begin
               next_state = ERROR;
            end
         end
         DONE, ERROR: begin
            if (!enable) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Outputs are decoded from next_state so they are registered yet line up
   // with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         start       <= 1'b0;
         busy        <= 1'b0;
         count       <= '0;
         finished    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         state       <= next_state;
         start       <= (next_state == ISSUE);
         busy        <= (next_state == ISSUE) || (next_state == WAIT);
         finished    <= (next_state == DONE);
         timeout_err <= (next_state == ERROR);
         if ((state == IDLE) && (next_state == ISSUE)) begin
            count <= '0;
         end else if ((state == WAIT) && done) begin
            count <= count_inc;
         end
      end
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer (COUNT_W=4 to exercise counter wrap).
module tb_step_sequencer;
   import sm_seq_pkg::*;

   localparam int COUNT_W = 4;
   localparam int TMO_W   = 8;

   logic               clk;
   logic               rst;
   logic               enable;
   logic [COUNT_W-1:0] step_limit;
   logic [TMO_W-1:0]   tmo_cycles;
   logic               done;
   logic               start;
   logic               busy;
   logic [COUNT_W-1:0] count;
   logic               finished;
   logic               timeout_err;

   int vectors;
   int miscompares;
   int start_pulses;

   step_sequencer #(
      .COUNT_W (COUNT_W),
      .TMO_W   (TMO_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .enable      (enable),
      .step_limit  (step_limit),
      .tmo_cycles  (tmo_cycles),
      .done        (done),
      .start       (start),
      .busy        (busy),
      .count       (count),
      .finished    (finished),
      .timeout_err (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (start === 1'b1) start_pulses++;
   end

   initial begin
      #200000;
      $display("[TB] FAIL global_timeout: observed running expected finished");
      $fatal(1, "[TB] simulation time limit exceeded");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      start_pulses = 0;
      rst          = 1'b1;
      enable       = 1'b1;
      step_limit   = 4'd3;
      tmo_cycles   = 8'd0;
      done         = 1'b0;

      // Reset held with enable high
      tick();
      tick();
      check_output("rst_start", start, 0);
      check_output("rst_busy", busy, 0);
      check_output("rst_count", count, 0);
      check_output("rst_finished", finished, 0);
      check_output("rst_timeout", timeout_err, 0);
      check_output("rst_state", dut.state, IDLE);
      check_output("rst_no_pulse", start_pulses, 0);

      // Limited run of 3 steps, done one cycle after each start
      rst = 1'b0;
      tick();
      check_output("lim_start1", start, 1);
      check_output("lim_busy1", busy, 1);
      check_output("lim_count0", count, 0);
      tick();
      check_output("lim_pulse_len", start, 0);
      check_output("lim_busy_wait", busy, 1);
      done = 1'b1;
      tick();
      check_output("lim_count1", count, 1);
      check_output("lim_start2", start, 1);
      done = 1'b0;
      tick();
      done = 1'b1;
      tick();
      check_output("lim_count2", count, 2);
      check_output("lim_start3", start, 1);
      done = 1'b0;
      tick();
      done = 1'b1;
      tick();
      check_output("lim_count3", count, 3);
      check_output("lim_finished", finished, 1);
      check_output("lim_busy_done", busy, 0);
      check_output("lim_no_start", start, 0);
      done = 1'b0;
      tick();
      check_output("lim_finished_held", finished, 1);
      check_output("lim_pulses", start_pulses, 3);
      enable = 1'b0;
      tick();
      check_output("lim_finished_clr", finished, 0);
      check_output("lim_idle", dut.state, IDLE);

      // Free-run with done held high: 17 steps wraps the 4-bit count to 1
      step_limit = 4'd0;
      done       = 1'b1;
      enable     = 1'b1;
      tick();
      check_output("free_count_clr", count, 0);
      for (int i = 1; i <= 17; i++) begin
         tick();
         tick();
         if (i == 15) check_output("free_count15", count, 15);
         if (i == 16) check_output("free_wrap0", count, 0);
         if (i == 17) check_output("free_wrap1", count, 1);
         if (finished !== 1'b0) check_output("free_no_finish", finished, 0);
      end
      // Enable drops during ISSUE: the step still runs, then return to IDLE
      enable = 1'b0;
      tick();
      check_output("issue_drop_busy", busy, 1);
      tick();
      check_output("issue_drop_count", count, 2);
      check_output("issue_drop_idle", busy, 0);
      tick();
      check_output("issue_drop_nostart", start, 0);
      done = 1'b0;

      // Watchdog of 5 cycles with done never arriving
      tmo_cycles   = 8'd5;
      enable       = 1'b1;
      start_pulses = 0;
      tick();
      tick();
      for (int i = 0; i < 4; i++) tick();
      check_output("tmo_not_yet", timeout_err, 0);
      check_output("tmo_busy_wait", busy, 1);
      tick();
      check_output("tmo_err", timeout_err, 1);
      check_output("tmo_busy_clr", busy, 0);
      check_output("tmo_count_held", count, 0);
      tick();
      tick();
      check_output("tmo_sticky", timeout_err, 1);
      check_output("tmo_one_start", start_pulses, 1);
      enable = 1'b0;
      tick();
      check_output("tmo_err_clr", timeout_err, 0);
      check_output("tmo_idle", dut.state, IDLE);

      // Done on the 5th WAIT cycle beats the watchdog
      enable = 1'b1;
      tick();
      tick();
      for (int i = 0; i < 4; i++) tick();
      done = 1'b1;
      tick();
      check_output("edge_no_err", timeout_err, 0);
      check_output("edge_count", count, 1);
      check_output("edge_reissue", start, 1);
      done = 1'b0;
      tick();
      check_output("edge_wait", busy, 1);
      enable = 1'b0;
      done   = 1'b1;
      tick();
      check_output("edge_count2", count, 2);
      done = 1'b0;

      // Enable drops one cycle after start; done arrives 4 cycles later
      tmo_cycles   = 8'd0;
      step_limit   = 4'd3;
      enable       = 1'b1;
      start_pulses = 0;
      tick();
      check_output("drop_start", start, 1);
      enable = 1'b0;
      tick();
      tick();
      tick();
      tick();
      check_output("drop_still_busy", busy, 1);
      done = 1'b1;
      tick();
      check_output("drop_count", count, 1);
      check_output("drop_idle", busy, 0);
      check_output("drop_no_finish", finished, 0);
      done = 1'b0;
      tick();
      check_output("drop_pulses", start_pulses, 1);

      // Reset during the start pulse truncates it
      enable = 1'b1;
      tick();
      check_output("trunc_start", start, 1);
      rst = 1'b1;
      tick();
      check_output("trunc_start_clr", start, 0);
      check_output("trunc_count", count, 0);
      check_output("trunc_state", dut.state, IDLE);
      rst    = 1'b0;
      enable = 1'b0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
